scan_hex_counter: RTL and testbench

Parametrised successor to the board-level 8-bit T-flip-flop counter: a WIDTH-bit synchronous up/down counter with prescaled enable, synchronous parallel load and terminal-count pulse, plus an integrated time-multiplexed driver for WIDTH/4 seven-segment digits. It sits between the switch/button inputs and the LEDR/AN/HEX0 board pins. It replaces the separate counter, clock-divider and display modules with a single-clock design: no derived clocks, only strobes.

---
 rtl/scan_counter_pkg.sv | 43 ++++
 rtl/scan_hex_counter_decoder.sv | 14 +
 rtl/scan_hex_counter.sv | 171 +++++++++++++++++
 tb/tb_scan_hex_counter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_counter_pkg.sv
// Shared definitions for scan_hex_counter: seven-segment patterns,
// scanner state encoding and the all-off anode value.
// Segment vectors are [0:6] = a..g, active-low (0 lights a segment).
package scan_counter_pkg;

  // All eight anodes off (active-low).
  localparam logic [7:0] AN_OFF = 8'hFF;

  // Every segment dark.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  // Hex glyphs 0..F, segment a in the leftmost literal bit.
  localparam logic [0:6] SEG_HEX [0:15] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  // BLANK: nothing shown yet after reset; SCAN: digits being multiplexed.
  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_e;

  // Glyph lookup for a single nibble.
  function automatic logic [0:6] hex_glyph(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/scan_hex_counter_decoder.sv
// hex7seg_decoder: purely combinational 4-bit to active-low a..g decode.
module hex7seg_decoder
  import scan_counter_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [0:6] seg_o
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    seg_o = hex_glyph(nibble_i);
  end

endmodule

// File: rtl/scan_hex_counter.sv
// scan_hex_counter: WIDTH-bit up/down counter with prescaled enable,
// synchronous load and terminal-count pulse, plus a time-multiplexed
// driver for WIDTH/4 seven-segment digits. Single clock, strobes only.
// Optional build macro LZ_BLANK_EN: blank digits above the most
// significant nonzero nibble (digit 0 is always shown).
module scan_hex_counter
  import scan_counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1,
  parameter int SCAN_DIV = 100000
) (
  input  logic             CLK100MHZ,
  input  logic             Clear,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Qout,
  output logic             TC,
  output logic [0:6]       HEX0,
  output logic [7:0]       AN
);

  localparam int DIGITS = WIDTH / 4;
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int PTR_W  = 3;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DIGITS - 1);

  // ---------------------------------------------------------------
  // Counter datapath
  // ---------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic             tc_q, tc_d;
  logic             step;
  logic             wrap;

  // Next-state for prescaler and counter: Load beats step beats hold.
  always_comb begin
    step      = Enable && (pre_cnt_q == PRE_LAST);
    wrap      = Up ? (qout_q == {WIDTH{1'b1}}) : (qout_q == {WIDTH{1'b0}});
    pre_cnt_d = pre_cnt_q;
    qout_d    = qout_q;
    tc_d      = 1'b0;
    if (Load) begin
      qout_d    = LoadValue;
      pre_cnt_d = '0;
    end else if (Enable) begin
      if (step) begin
        pre_cnt_d = '0;
        qout_d    = Up ? (qout_q + 1'b1) : (qout_q - 1'b1);
        // TC is only raised by a step that wraps, never by a load.
        tc_d      = wrap;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  // Counter, prescaler phase and terminal-count registers.
  always_ff @(posedge CLK100MHZ or posedge Clear) begin
    if (Clear) begin
      pre_cnt_q <= '0;
      qout_q    <= '0;
      tc_q      <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      qout_q    <= qout_d;
      tc_q      <= tc_d;
    end
  end

  // ---------------------------------------------------------------
  // Display scanner
  // ---------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt_q;
  logic              slot_strobe;

  assign slot_strobe = (scan_cnt_q == SCAN_LAST);

  // Free-running slot timer; it keeps running regardless of counter activity.
  always_ff @(posedge CLK100MHZ or posedge Clear) begin
    if (Clear) begin
      scan_cnt_q <= '0;
    end else if (slot_strobe) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  scan_state_e      state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [7:0]       an_q;
  logic [0:6]       hex_q;

  logic [PTR_W-1:0] ptr_adv;
  logic [31:0]      q_pad;
  logic [3:0]       nibble;
  logic [0:6]       seg_dec;
  logic             lead_zero;
  logic [7:0]       an_nxt;
  logic [0:6]       seg_nxt;

  // The pointer starts at the last digit so the first strobe lands on digit 0.
  assign ptr_adv = (ptr_q == PTR_LAST) ? '0 : (ptr_q + 1'b1);

  // Zero-extend so every pointer value indexes a legal nibble.
  assign q_pad  = 32'(qout_q);
  assign nibble = q_pad[{ptr_adv, 2'b00} +: 4];

  hex7seg_decoder u_dec (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  // Glyph and anode pattern for the slot about to begin.
  always_comb begin
`ifdef LZ_BLANK_EN
    lead_zero = (ptr_adv != '0) && ((q_pad >> {ptr_adv, 2'b00}) == 32'd0);
`else
    lead_zero = 1'b0;
`endif
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    if (!lead_zero) begin
      an_nxt[ptr_adv] = 1'b0;
      seg_nxt         = seg_dec;
    end
  end

  // Scanner FSM: sample, decode and latch one digit per slot strobe.
  always_ff @(posedge CLK100MHZ or posedge Clear) begin
    if (Clear) begin
      state_q <= BLANK;
      ptr_q   <= PTR_LAST;
      an_q    <= AN_OFF;
      hex_q   <= SEG_BLANK;
    end else begin
      unique case (state_q)
        BLANK: begin
          if (slot_strobe) begin
            state_q <= SCAN;
            ptr_q   <= ptr_adv;
            an_q    <= an_nxt;
            hex_q   <= seg_nxt;
          end
        end
        SCAN: begin
          // Outputs stay frozen for the whole slot; only strobes refresh them.
          if (slot_strobe) begin
            ptr_q <= ptr_adv;
            an_q  <= an_nxt;
            hex_q <= seg_nxt;
          end
        end
      endcase
    end
  end

  assign Qout = qout_q;
  assign TC   = tc_q;
  assign HEX0 = hex_q;
  assign AN   = an_q;

endmodule

// File: tb/tb_scan_hex_counter.sv
// Scoreboard bench for scan_hex_counter (WIDTH=8, SCAN_DIV=4).
// dut1 uses PRESCALE=1, dut2 uses PRESCALE=3. Expectations are queued by
// the stimulus process tagged with the cycle they apply to; a monitor pops
// and compares them one cycle-tick later.
module tb_scan_hex_counter;

  localparam logic [3:0] M_Q   = 4'b0001;
  localparam logic [3:0] M_TC  = 4'b0010;
  localparam logic [3:0] M_ALL = 4'b1111;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S3   = 7'b0000110;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] S7   = 7'b0001111;
  localparam logic [6:0] SA   = 7'b0001000;

`ifdef LZ_BLANK_EN
  localparam logic [7:0] AN_D1_05 = 8'hFF;
  localparam logic [6:0] HX_D1_05 = S_BL;
`else
  localparam logic [7:0] AN_D1_05 = 8'hFD;
  localparam logic [6:0] HX_D1_05 = S0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, en, up, ld;
  logic [7:0] lv;
  logic [7:0] q1, an1;
  logic       tc1;
  logic [0:6] hex1;

  logic       en2, up2, ld2;
  logic [7:0] lv2;
  logic [7:0] q2, an2;
  logic       tc2;
  logic [0:6] hex2;

  scan_hex_counter #(.WIDTH(8), .PRESCALE(1), .SCAN_DIV(4)) dut1 (
    .CLK100MHZ (clk),
    .Clear     (clr),
    .Enable    (en),
    .Up        (up),
    .Load      (ld),
    .LoadValue (lv),
    .Qout      (q1),
    .TC        (tc1),
    .HEX0      (hex1),
    .AN        (an1)
  );

  scan_hex_counter #(.WIDTH(8), .PRESCALE(3), .SCAN_DIV(4)) dut2 (
    .CLK100MHZ (clk),
    .Clear     (clr),
    .Enable    (en2),
    .Up        (up2),
    .Load      (ld2),
    .LoadValue (lv2),
    .Qout      (q2),
    .TC        (tc2),
    .HEX0      (hex2),
    .AN        (an2)
  );

  typedef struct {
    int         cyc;
    bit         sel;
    logic [3:0] mask;
    logic [7:0] q;
    logic       tc;
    logic [7:0] an;
    logic [6:0] hex;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  // Pop and compare every expectation due at or before the current cycle.
  task automatic drain();
    exp_t       e;
    logic [7:0] aq, aan;
    logic       atc;
    logic [6:0] ahx;
    bit         bad;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      aq  = e.sel ? q2 : q1;
      atc = e.sel ? tc2 : tc1;
      aan = e.sel ? an2 : an1;
      ahx = e.sel ? hex2 : hex1;
      bad = (e.mask[0] && (aq  !== e.q))  ||
            (e.mask[1] && (atc !== e.tc)) ||
            (e.mask[2] && (aan !== e.an)) ||
            (e.mask[3] && (ahx !== e.hex));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s cyc=%0d: got q=%h tc=%b an=%h hex=%b, want q=%h tc=%b an=%h hex=%b (mask %b)",
                 e.name, cyc, aq, atc, aan, ahx, e.q, e.tc, e.an, e.hex, e.mask);
      end
    end
  endtask

  // Monitor: one tick after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      drain();
    end
  end

  // Monitor path for checks that must happen between clock edges.
  initial begin
    forever begin
      @(chk_ev);
      drain();
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Queue an expectation for the state after the next rising edge.
  task automatic push(input string n, input bit s, input logic [3:0] m,
                      input logic [7:0] q, input logic t,
                      input logic [7:0] a, input logic [6:0] h);
    exp_t e;
    e.cyc = cyc + 1; e.sel = s; e.mask = m; e.q = q; e.tc = t;
    e.an = a; e.hex = h; e.name = n;
    sb.push_back(e);
  endtask

  // Queue an expectation for right now and wake the monitor.
  task automatic push_now(input string n, input logic [7:0] q,
                          input logic [7:0] a, input logic [6:0] h);
    exp_t e;
    e.cyc = cyc; e.sel = 1'b0; e.mask = M_ALL; e.q = q; e.tc = 1'b0;
    e.an = a; e.hex = h; e.name = n;
    sb.push_back(e);
    -> chk_ev;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; lv = 8'h00;
    en2 = 1'b0; up2 = 1'b1; ld2 = 1'b0; lv2 = 8'h00;
    tick(); tick();                                         // cyc 2
    // Release clear and count up; first strobe lands at cycle 6.
    clr = 1'b0; en = 1'b1; up = 1'b1;
    push("reset_then_up1", 0, M_ALL, 8'h01, 0, 8'hFF, S_BL); tick();
    push("up2_blank",      0, M_ALL, 8'h02, 0, 8'hFF, S_BL); tick();
    push("up3_blank",      0, M_ALL, 8'h03, 0, 8'hFF, S_BL); tick();
    push("first_digit",    0, M_ALL, 8'h04, 0, 8'hFE, S3);   tick();
    push("up5",            0, M_ALL, 8'h05, 0, 8'hFE, S3);   tick();  // cyc 7
    // Load FE, wrap upward.
    en = 1'b0; ld = 1'b1; lv = 8'hFE;
    push("load_fe",      0, M_Q | M_TC, 8'hFE, 0, 8'h00, S_BL); tick();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    push("up_to_ff",     0, M_Q | M_TC, 8'hFF, 0, 8'h00, S_BL); tick();
    push("wrap_up_tc",   0, M_Q | M_TC, 8'h00, 1, 8'h00, S_BL); tick();
    push("tc_one_cycle", 0, M_Q | M_TC, 8'h01, 0, 8'h00, S_BL); tick();  // cyc 11
    // Count down through zero.
    up = 1'b0;
    push("down_to_00",   0, M_Q | M_TC, 8'h00, 0, 8'h00, S_BL); tick();
    push("wrap_down_tc", 0, M_Q | M_TC, 8'hFF, 1, 8'h00, S_BL); tick();  // cyc 13
    en = 1'b0; ld = 1'b1; lv = 8'h00;
    push("load_00",      0, M_Q | M_TC, 8'h00, 0, 8'h00, S_BL); tick();
    // Load coincides with a wrapping down-step: load wins, no TC.
    en = 1'b1; up = 1'b0; lv = 8'h5A;
    push("load_beats_wrap", 0, M_Q | M_TC, 8'h5A, 0, 8'h00, S_BL); tick(); // cyc 15
    en = 1'b0; lv = 8'h3A;
    push("load_3a",      0, M_Q | M_TC, 8'h3A, 0, 8'h00, S_BL); tick();
    ld = 1'b0; tick(); tick();                              // cyc 18
    push("scan_d1_3",    0, M_ALL, 8'h3A, 0, 8'hFD, S3); tick();
    push("scan_d1_hold", 0, M_ALL, 8'h3A, 0, 8'hFD, S3); tick();
    tick();                                                 // cyc 21
    push("scan_d0_a",    0, M_ALL, 8'h3A, 0, 8'hFE, SA); tick();
    tick();                                                 // cyc 23
    // Change Qout mid-slot: glyph must stay frozen until the next strobe.
    ld = 1'b1; lv = 8'h77;
    push("midslot_frozen",  0, M_ALL, 8'h77, 0, 8'hFE, SA); tick();
    ld = 1'b0;
    push("midslot_frozen2", 0, M_ALL, 8'h77, 0, 8'hFE, SA); tick();
    push("next_slot_7",     0, M_ALL, 8'h77, 0, 8'hFD, S7); tick();  // cyc 26
    ld = 1'b1; lv = 8'h05;
    push("load_05", 0, M_Q | M_TC, 8'h05, 0, 8'h00, S_BL); tick();
    ld = 1'b0; tick(); tick();                              // cyc 29
    push("d0_shows_5", 0, M_ALL, 8'h05, 0, 8'hFE, S5); tick();
    tick(); tick(); tick();                                 // cyc 33
    push("d1_of_05",      0, M_ALL, 8'h05, 0, AN_D1_05, HX_D1_05); tick();
    push("d1_of_05_hold", 0, M_ALL, 8'h05, 0, AN_D1_05, HX_D1_05); tick(); // cyc 35
    // Clear mid-slot: outputs must drop before any clock edge.
    clr = 1'b1;
    #1;
    push_now("clear_async", 8'h00, 8'hFF, S_BL);
    #1;
    tick();                                                 // cyc 36
    clr = 1'b0; en = 1'b0;
    push("after_clear",         0, M_ALL, 8'h00, 0, 8'hFF, S_BL); tick();
    tick();                                                 // cyc 38
    push("pre_first_strobe",    0, M_ALL, 8'h00, 0, 8'hFF, S_BL); tick();
    push("first_digit_restart", 0, M_ALL, 8'h00, 0, 8'hFE, S0);   tick(); // cyc 40
    // PRESCALE=3 instance: one step every third enabled cycle.
    en2 = 1'b1;
    push("p3_phase0", 1, M_Q | M_TC, 8'h00, 0, 8'h00, S_BL); tick();
    push("p3_phase1", 1, M_Q | M_TC, 8'h00, 0, 8'h00, S_BL); tick();
    push("p3_step1",  1, M_Q | M_TC, 8'h01, 0, 8'h00, S_BL); tick();
    tick(); tick();                                         // cyc 45
    push("p3_step2",  1, M_Q | M_TC, 8'h02, 0, 8'h00, S_BL); tick();
    tick(); tick();                                         // cyc 48
    push("p3_step3",  1, M_Q | M_TC, 8'h03, 0, 8'h00, S_BL); tick();
    tick();                                                 // cyc 50, phase 1
    en2 = 1'b0;
    tick(); tick(); tick(); tick();                         // cyc 54
    push("p3_hold",   1, M_Q | M_TC, 8'h03, 0, 8'h00, S_BL); tick();  // cyc 55
    en2 = 1'b1;
    push("p3_resume_phase", 1, M_Q | M_TC, 8'h03, 0, 8'h00, S_BL); tick();
    push("p3_resume_step",  1, M_Q | M_TC, 8'h04, 0, 8'h00, S_BL); tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
